bg_tx_lane_ctrl: RTL

BG_TX_LANE_CTRL -- requirements
Module: bg_tx_lane_ctrl

---
 rtl/bg_tx_pkg.sv | 18 +
 rtl/bg_dly_seq.sv | 132 +++++++++++++
 rtl/bg_tx_lane_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bg_tx_pkg.sv
// Shared definitions for the bank-group TX lane controller.
// Holds the delay sequencer state encoding and the lane/phase geometry.
// No ports; imported by bg_dly_seq and bg_tx_lane_ctrl.
package bg_tx_pkg;

    localparam int NUM_LANES             = 2;
    localparam int NUM_PHASES            = 4;
    localparam int DEFAULT_SETTLE_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MOVE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } dly_state_t;

endpackage

// File: rtl/bg_dly_seq.sv
// Delay-line sequencer: optional LOAD, then STEPS MOVE pulses, each followed by SETTLE_CYCLES idle cycles.
// Latency: first pulse 1 cycle after acceptance; ack registered, 1 cycle after DONE (2 cycles for an empty request).
// Backpressure: requests are accepted only in IDLE; req outside IDLE is ignored (busy is high there).
// Ports: clk/rst_n (sync active-low); req/req_lane/req_dir/req_load/req_steps request;
//        oor = out-of-range of the latched lane; busy/ack/err status;
//        move_pulse/load_pulse one-cycle strobes; lane/dir latched selection for the top-level demux.
module bg_dly_seq
    import bg_tx_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int STEP_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              req_lane,
    input  logic              req_dir,
    input  logic              req_load,
    input  logic [STEP_W-1:0] req_steps,
    input  logic              oor,
    output logic              busy,
    output logic              ack,
    output logic              err,
    output logic              move_pulse,
    output logic              load_pulse,
    output logic              lane,
    output logic              dir
);

    // Settle counter runs SETTLE_CYCLES-1 down to 0; 0 marks the last settle cycle.
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

    dly_state_t        state;
    dly_state_t        state_nxt;
    logic [STEP_W-1:0] steps_q;
    logic [3:0]        settle_cnt;
    logic              accept;
    logic              abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        abort      = 1'b0;
        move_pulse = 1'b0;
        load_pulse = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    accept = 1'b1;
                    if (req_load) begin
                        state_nxt = ST_LOAD;
                    end else if (req_steps != '0) begin
                        state_nxt = ST_MOVE;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                load_pulse = 1'b1;
                state_nxt  = ST_SETTLE;
            end
            ST_MOVE: begin
                move_pulse = 1'b1;
                state_nxt  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    // Out-of-range is only trusted once the line has settled.
                    if (oor) begin
                        abort     = 1'b1;
                        state_nxt = ST_DONE;
                    end else if (steps_q != '0) begin
                        state_nxt = ST_MOVE;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            steps_q    <= '0;
            settle_cnt <= 4'd0;
            lane       <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
            ack        <= 1'b0;
        end else begin
            ack <= (state == ST_DONE);
            if (accept) begin
                lane    <= req_lane;
                dir     <= req_dir;
                steps_q <= req_steps;
                err     <= 1'b0;
            end
            if (move_pulse) begin
                steps_q <= steps_q - STEP_ONE;
            end
            if (load_pulse || move_pulse) begin
                settle_cnt <= SETTLE_LAST;
            end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            // Sticky until the next accepted request; leftover steps are dropped.
            if (abort) begin
                err     <= 1'b1;
                steps_q <= '0;
            end
        end
    end

endmodule

// File: rtl/bg_tx_lane_ctrl.sv
// Two-lane bank-group TX controller: phase demux into per-lane serializer/OE registers plus delay-line sequencing.
// Latency: TX_DATA/OE_DATA 1 cycle after input; delay-line strobes per bg_dly_seq.
// Backpressure: none on the data path; delay requests wait for DLY_BUSY low (held DLY_REQ is ignored while busy).
// Ports: FAB_CLK, RESET_N (sync active-low); BG_PHASE/BG_VALID/DRIVE_EN -> TX_DATA_x/OE_DATA_x;
//        DLY_* request/status; DELAY_LINE_* per-lane controls and out-of-range inputs; TAP_POS_x tap tracking.
// Build option: define BG_TX_TAP_TRACK_EN to build the TAP_POS counters; otherwise TAP_POS_x are tied to 0.
module bg_tx_lane_ctrl
    import bg_tx_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int STEP_W        = 8
) (
    input  logic                      FAB_CLK,
    input  logic                      RESET_N,
    input  logic [2*NUM_PHASES-1:0]   BG_PHASE,
    input  logic                      BG_VALID,
    input  logic                      DRIVE_EN,
    output logic [NUM_PHASES-1:0]     TX_DATA_0,
    output logic [NUM_PHASES-1:0]     TX_DATA_1,
    output logic [NUM_PHASES-1:0]     OE_DATA_0,
    output logic [NUM_PHASES-1:0]     OE_DATA_1,
    input  logic                      DLY_REQ,
    input  logic                      DLY_LANE,
    input  logic                      DLY_DIR,
    input  logic                      DLY_LOAD,
    input  logic [STEP_W-1:0]         DLY_STEPS,
    output logic                      DLY_BUSY,
    output logic                      DLY_ACK,
    output logic                      DLY_ERR,
    output logic                      DELAY_LINE_MOVE_0,
    output logic                      DELAY_LINE_MOVE_1,
    output logic                      DELAY_LINE_DIRECTION_0,
    output logic                      DELAY_LINE_DIRECTION_1,
    output logic                      DELAY_LINE_LOAD_0,
    output logic                      DELAY_LINE_LOAD_1,
    input  logic                      DELAY_LINE_OUT_OF_RANGE_0,
    input  logic                      DELAY_LINE_OUT_OF_RANGE_1,
    output logic [STEP_W-1:0]         TAP_POS_0,
    output logic [STEP_W-1:0]         TAP_POS_1
);

    // ---------------- data path ----------------
    logic [NUM_PHASES-1:0] lane0_bits;
    logic [NUM_PHASES-1:0] lane1_bits;

    // Even bits of each phase pair go to lane 0, odd bits to lane 1.
    always_comb begin
        lane0_bits = '0;
        lane1_bits = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            lane0_bits[p] = BG_PHASE[2*p];
            lane1_bits[p] = BG_PHASE[2*p+1];
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            TX_DATA_0 <= '0;
            TX_DATA_1 <= '0;
            OE_DATA_0 <= '0;
            OE_DATA_1 <= '0;
        end else begin
            if (BG_VALID) begin
                TX_DATA_0 <= lane0_bits;
                TX_DATA_1 <= lane1_bits;
            end
            // OE tracks DRIVE_EN every cycle, independent of BG_VALID.
            OE_DATA_0 <= {NUM_PHASES{DRIVE_EN}};
            OE_DATA_1 <= {NUM_PHASES{DRIVE_EN}};
        end
    end

    // ---------------- delay sequencer ----------------
    logic seq_move;
    logic seq_load;
    logic seq_lane;
    logic seq_dir;
    logic sel_oor;

    assign sel_oor = seq_lane ? DELAY_LINE_OUT_OF_RANGE_1 : DELAY_LINE_OUT_OF_RANGE_0;

    bg_dly_seq #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .STEP_W        (STEP_W)
    ) u_dly_seq (
        .clk        (FAB_CLK),
        .rst_n      (RESET_N),
        .req        (DLY_REQ),
        .req_lane   (DLY_LANE),
        .req_dir    (DLY_DIR),
        .req_load   (DLY_LOAD),
        .req_steps  (DLY_STEPS),
        .oor        (sel_oor),
        .busy       (DLY_BUSY),
        .ack        (DLY_ACK),
        .err        (DLY_ERR),
        .move_pulse (seq_move),
        .load_pulse (seq_load),
        .lane       (seq_lane),
        .dir        (seq_dir)
    );

    // Lane demux: the unselected lane sees all zeros. Direction keeps the
    // latched value after DONE because lane/dir only change on acceptance.
    assign DELAY_LINE_MOVE_0      = seq_move & ~seq_lane;
    assign DELAY_LINE_MOVE_1      = seq_move &  seq_lane;
    assign DELAY_LINE_LOAD_0      = seq_load & ~seq_lane;
    assign DELAY_LINE_LOAD_1      = seq_load &  seq_lane;
    assign DELAY_LINE_DIRECTION_0 = seq_dir  & ~seq_lane;
    assign DELAY_LINE_DIRECTION_1 = seq_dir  &  seq_lane;

    // ---------------- tap tracking ----------------
`ifdef BG_TX_TAP_TRACK_EN
    localparam logic [STEP_W-1:0] TAP_ONE = STEP_W'(1);

    logic [STEP_W-1:0] tap_0;
    logic [STEP_W-1:0] tap_1;

    // LOAD re-centres the count to 0; MOVE steps by one and saturates at both ends.
    function automatic logic [STEP_W-1:0] tap_next(input logic [STEP_W-1:0] cur,
                                                   input logic ld,
                                                   input logic mv,
                                                   input logic up);
        logic [STEP_W-1:0] r;
        r = cur;
        if (ld) begin
            r = '0;
        end else if (mv) begin
            if (up && cur != '1) begin
                r = cur + TAP_ONE;
            end else if (!up && cur != '0) begin
                r = cur - TAP_ONE;
            end
        end
        return r;
    endfunction

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            tap_0 <= '0;
            tap_1 <= '0;
        end else begin
            tap_0 <= tap_next(tap_0, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, seq_dir);
            tap_1 <= tap_next(tap_1, DELAY_LINE_LOAD_1, DELAY_LINE_MOVE_1, seq_dir);
        end
    end

    assign TAP_POS_0 = tap_0;
    assign TAP_POS_1 = tap_1;
`else
    assign TAP_POS_0 = '0;
    assign TAP_POS_1 = '0;
`endif

endmodule
